// File: rtl/obstacle_pool_controller.sv
// Pool of falling obstacles: allocates the lowest idle slot on spawn, moves
// every falling obstacle down by STEP on each frame tick and frees a slot
// once its obstacle passes the bottom of the visible area.
`timescale 1ns/1ps
module obstacle_pool_controller #(
  parameter int N_SLOTS  = 4,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int SCREEN_H = 480,
  parameter int START_Y  = 0,
  parameter int STEP     = 4,
  parameter int TICK_DIV = 833333
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   pause,
  input  logic                   spawn_valid,
  input  logic [X_W-1:0]         spawn_x,
  input  logic [1:0]             spawn_type,
  output logic                   spawn_ready,
  output logic [N_SLOTS-1:0]     obstacle_active,
  output logic [N_SLOTS*X_W-1:0] obstacle_x,
  output logic [N_SLOTS*Y_W-1:0] obstacle_y,
  output logic [N_SLOTS*2-1:0]   obstacle_type,
  output logic                   tick,
  output logic [N_SLOTS-1:0]     despawn_mask
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [Y_W:0]     SCREEN_LIM = (Y_W+1)'(SCREEN_H);
  localparam logic [Y_W:0]     STEP_EXT   = (Y_W+1)'(STEP);
  localparam logic [Y_W-1:0]   START_VAL  = Y_W'(START_Y);

  typedef enum logic {
    SLOT_IDLE    = 1'b0,
    SLOT_FALLING = 1'b1
  } slot_state_t;

  slot_state_t      state_r [N_SLOTS];
  logic [X_W-1:0]   x_r     [N_SLOTS];
  logic [Y_W-1:0]   y_r     [N_SLOTS];
  logic [1:0]       type_r  [N_SLOTS];
  logic [Y_W:0]     y_next_s[N_SLOTS];
  logic [N_SLOTS-1:0] alloc_oh_s;
  logic [N_SLOTS-1:0] despawn_r;
  logic [CNT_W-1:0] cnt_r;
  logic             tick_r;
  logic             accept_s;

  // Flatten per-slot registers onto the renderer buses.
  for (genvar g = 0; g < N_SLOTS; g++) begin : g_flat
    assign obstacle_active[g]          = (state_r[g] == SLOT_FALLING);
    assign obstacle_x[g*X_W +: X_W]    = x_r[g];
    assign obstacle_y[g*Y_W +: Y_W]    = y_r[g];
    assign obstacle_type[g*2 +: 2]     = type_r[g];
  end

  assign spawn_ready  = |(~obstacle_active);
  assign accept_s     = spawn_valid && spawn_ready && !clear;
  assign tick         = tick_r;
  assign despawn_mask = despawn_r;

  // Pick the lowest idle slot and precompute each slot's moved position.
  always_comb begin
    logic taken_s;
    taken_s    = 1'b0;
    alloc_oh_s = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      alloc_oh_s[i] = !taken_s && (state_r[i] == SLOT_IDLE);
      taken_s       = taken_s || (state_r[i] == SLOT_IDLE);
      y_next_s[i]   = {1'b0, y_r[i]} + STEP_EXT;
    end
  end

  // Frame tick divider: holds while paused, restarts on clear.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (clear) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (pause) begin
      cnt_r  <= cnt_r;
      tick_r <= 1'b0;
    end else begin
      tick_r <= (cnt_r == CNT_LAST);
      cnt_r  <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_W'(1);
    end
  end

  // Per-slot state machine: spawn loads an idle slot, ticks move falling
  // slots, and a slot leaving the screen returns to idle with a pulse.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      despawn_r <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        state_r[i] <= SLOT_IDLE;
        x_r[i]     <= '0;
        y_r[i]     <= '0;
        type_r[i]  <= 2'b00;
      end
    end else if (clear) begin
      despawn_r <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        state_r[i] <= SLOT_IDLE;
      end
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        despawn_r[i] <= 1'b0;
        case (state_r[i])
          SLOT_FALLING: begin
            if (tick_r) begin
              if (y_next_s[i] >= SCREEN_LIM) begin
                state_r[i]   <= SLOT_IDLE;
                despawn_r[i] <= 1'b1;
              end else begin
                y_r[i] <= y_next_s[i][Y_W-1:0];
              end
            end else begin
              y_r[i] <= y_r[i];
            end
          end
          SLOT_IDLE: begin
            if (accept_s && alloc_oh_s[i]) begin
              state_r[i] <= SLOT_FALLING;
              x_r[i]     <= spawn_x;
              y_r[i]     <= START_VAL;
              type_r[i]  <= spawn_type;
            end else begin
              state_r[i] <= SLOT_IDLE;
            end
          end
          default: begin
            state_r[i] <= SLOT_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_obstacle_pool_controller.sv
// Scoreboard bench for obstacle_pool_controller: a reference model predicts
// the full output state after every clock edge, a monitor compares it.
`timescale 1ns/1ps
module tb_obstacle_pool_controller;

  localparam int NS = 4;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int SH = 64;
  localparam int SY = 0;
  localparam int ST = 8;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset, clear, pause, spawn_valid;
  logic [XW-1:0] spawn_x;
  logic [1:0] spawn_type;
  logic spawn_ready;
  logic [NS-1:0] obstacle_active;
  logic [NS*XW-1:0] obstacle_x;
  logic [NS*YW-1:0] obstacle_y;
  logic [NS*2-1:0] obstacle_type;
  logic tick;
  logic [NS-1:0] despawn_mask;

  always #5 clk = ~clk;

  obstacle_pool_controller #(
    .N_SLOTS(NS), .X_W(XW), .Y_W(YW), .SCREEN_H(SH),
    .START_Y(SY), .STEP(ST), .TICK_DIV(TD)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .clear(clear), .pause(pause),
    .spawn_valid(spawn_valid), .spawn_x(spawn_x), .spawn_type(spawn_type),
    .spawn_ready(spawn_ready), .obstacle_active(obstacle_active),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .obstacle_type(obstacle_type), .tick(tick), .despawn_mask(despawn_mask)
  );

  typedef struct {
    logic [NS-1:0]    act;
    logic [NS*XW-1:0] x;
    logic [NS*YW-1:0] y;
    logic [NS*2-1:0]  ty;
    logic             tk;
    logic [NS-1:0]    desp;
    logic             rdy;
    bit               chk_rdy;
  } snap_t;

  snap_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit m_act[NS];
  int m_x[NS], m_y[NS], m_ty[NS];
  bit m_tick;
  bit m_desp[NS];
  int m_edges;   // unpaused edges since reset/clear

  task automatic model_step(input bit rst, input bit clr, input bit pau,
                            input bit sv, input int sx, input int sty);
    bit was_act[NS];
    bit any_free;
    int slot;
    for (int i = 0; i < NS; i++) was_act[i] = m_act[i];
    if (!rst) begin
      for (int i = 0; i < NS; i++) begin
        m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_ty[i] = 0; m_desp[i] = 0;
      end
      m_tick = 0; m_edges = 0;
    end else if (clr) begin
      for (int i = 0; i < NS; i++) begin m_act[i] = 0; m_desp[i] = 0; end
      m_tick = 0; m_edges = 0;
    end else begin
      any_free = 0; slot = -1;
      for (int i = 0; i < NS; i++)
        if (!was_act[i]) begin any_free = 1; if (slot < 0) slot = i; end
      for (int i = 0; i < NS; i++) begin
        m_desp[i] = 0;
        if (was_act[i] && m_tick) begin
          if (m_y[i] + ST >= SH) begin m_act[i] = 0; m_desp[i] = 1; end
          else m_y[i] = m_y[i] + ST;
        end
      end
      if (sv && any_free) begin
        m_act[slot] = 1; m_x[slot] = sx; m_y[slot] = SY; m_ty[slot] = sty;
      end
      if (pau) m_tick = 0;
      else begin m_edges++; m_tick = (m_edges % TD) == 0; end
    end
  endtask

  function automatic snap_t make_snap(input bit chk_rdy);
    snap_t s;
    s.rdy = 0;
    for (int i = 0; i < NS; i++) begin
      s.act[i]          = m_act[i];
      s.x[i*XW +: XW]   = XW'(m_x[i]);
      s.y[i*YW +: YW]   = YW'(m_y[i]);
      s.ty[i*2 +: 2]    = 2'(m_ty[i]);
      s.desp[i]         = m_desp[i];
      if (!m_act[i]) s.rdy = 1;
    end
    s.tk = m_tick;
    s.chk_rdy = chk_rdy;
    return s;
  endfunction

  // one clock cycle: drive inputs, predict, push expectation after the edge
  task automatic cyc(input bit rst, input bit clr, input bit pau,
                     input bit sv, input int sx, input int sty);
    snap_t s;
    @(negedge clk); #1;
    reset = rst; clear = clr; pause = pau; spawn_valid = sv;
    spawn_x = XW'(sx); spawn_type = 2'(sty);
    model_step(rst, clr, pau, sv, sx, sty);
    s = make_snap(rst);
    @(posedge clk);
    sbq.push_back(s);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // monitor: compare DUT outputs against queued expectations
  always @(negedge clk) begin
    snap_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      vectors++;
      chk("active",  64'(obstacle_active), 64'(e.act));
      chk("x",       64'(obstacle_x),      64'(e.x));
      chk("y",       64'(obstacle_y),      64'(e.y));
      chk("type",    64'(obstacle_type),   64'(e.ty));
      chk("tick",    64'(tick),            64'(e.tk));
      chk("despawn", 64'(despawn_mask),    64'(e.desp));
      if (e.chk_rdy) chk("spawn_ready", 64'(spawn_ready), 64'(e.rdy));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; clear = 1'b0; pause = 1'b0; spawn_valid = 1'b1;
    spawn_x = '0; spawn_type = 2'b00;
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_ty[i] = 0; m_desp[i] = 0;
    end
    m_tick = 0; m_edges = 0;

    // reset held with a spawn request pending
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 55, 1);
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0, 0, 0);

    // single fall through to despawn
    cyc(1, 0, 0, 1, 100, 2);
    for (int k = 0; k < 40; k++) cyc(1, 0, 0, 0, 0, 0);

    // fill the pool, keep requesting while full
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 1, 10 * (k + 1), k);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 1, 50, 3);
    for (int k = 0; k < 40; k++) cyc(1, 0, 0, (k % 7) == 0, 60 + k, k % 4);

    // pause with a spawn in the middle, then clear with a spawn
    for (int k = 0; k < 20; k++) cyc(1, 0, 1, k == 10, 300, 1);
    cyc(1, 1, 0, 1, 400, 3);
    for (int k = 0; k < 10; k++) cyc(1, 0, 0, k == 2, 500, 2);

    // randomized traffic including pause, clear and reset
    for (int k = 0; k < 700; k++) begin
      int r;
      r = int'($urandom_range(0, 999));
      cyc(r != 0, r < 15 && r > 0, r >= 900 && r < 980,
          $urandom_range(0, 2) == 0,
          int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
    end

    // reset while obstacles are falling
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 1, 200 + k, k);
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0, 0, 0);

    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
